// File: rtl/neuro_mem_arbiter.sv
// neuro_mem_arbiter
//   Shares one memory read port among NUM_UNITS requesting cores. The winner of
//   each arbitration is registered onto the memory bus. Its index is pushed into
//   an in-order ID FIFO so that returned DRDY/MAERR reach the core that owns the
//   oldest outstanding read.
//   Build option: define NEURO_ARB_FIXPRIO_EN for fixed priority (lowest index
//   wins). Leave it undefined for round robin starting after the last winner.
module neuro_mem_arbiter #(
   parameter int NUM_UNITS = 4,
   parameter int DEPTH     = 8,
   parameter int IDW       = $clog2(NUM_UNITS)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NUM_UNITS-1:0]    ReqACT,
   input  logic [3*NUM_UNITS-1:0]  ReqSEL,
   input  logic [35*NUM_UNITS-1:0] ReqOffset,
   input  logic [NUM_UNITS-1:0]    ReqSIZE,
   input  logic [NUM_UNITS-1:0]    ReqTAG,
   output logic [NUM_UNITS-1:0]    ReqNEXT,
   output logic                    MemACT,
   input  logic                    MemNEXT,
   output logic [2:0]              MemSEL,
   output logic [34:0]             MemOffset,
   output logic                    SIZE,
   output logic                    TAGo,
   input  logic                    DRDY,
   input  logic                    TAGi,
   input  logic [63:0]             DTi,
   input  logic                    MAERR,
   output logic [NUM_UNITS-1:0]    UnitDRDY,
   output logic [NUM_UNITS-1:0]    UnitMAERR,
   output logic                    UnitTAG,
   output logic [63:0]             UnitDT,
   output logic                    ORPHAN
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PSW = IDW + 1;

   logic                 mem_act_q, size_q, tag_q, orphan_q;
   logic [2:0]           mem_sel_q;
   logic [34:0]          mem_off_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [IDW-1:0]       fifo_q [DEPTH];
   logic [IDW-1:0]       base, win_idx, head;
   logic [PSW-1:0]       pos;
   logic                 win_found, grant, ret, pop;
   logic [2:0]           win_sel;
   logic [34:0]          win_off;
   logic                 win_size, win_tag;
`ifndef NEURO_ARB_FIXPRIO_EN
   logic [IDW-1:0]       last_q;
`endif

   // The search starts at index 0 for fixed priority, or one past the last winner.
`ifdef NEURO_ARB_FIXPRIO_EN
   assign base = '0;
`else
   assign base = (last_q == IDW'(NUM_UNITS - 1)) ? '0 : last_q + IDW'(1);
`endif

   // Find the first active request at or after base, wrapping around the unit count.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      pos       = '0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         pos = {1'b0, base} + PSW'(k);
         if (pos >= PSW'(NUM_UNITS)) pos = pos - PSW'(NUM_UNITS);
         if (ReqACT[pos[IDW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = pos[IDW-1:0];
         end
      end
   end

   // Select the winning core's request fields.
   always_comb begin
      win_sel  = '0;
      win_off  = '0;
      win_size = 1'b0;
      win_tag  = 1'b0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (win_idx == IDW'(k)) begin
            win_sel  = ReqSEL[3*k +: 3];
            win_off  = ReqOffset[35*k +: 35];
            win_size = ReqSIZE[k];
            win_tag  = ReqTAG[k];
         end
      end
   end

   // Grant when the bus register is free or draining and the ID FIFO has room.
   assign grant = ~RESET & (~mem_act_q | MemNEXT) & (cnt_q < CW'(DEPTH)) & win_found;
   assign ret   = DRDY | MAERR;
   assign pop   = ret & (cnt_q != '0);
   assign head  = fifo_q[rd_ptr_q];

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
         assign ReqNEXT[gi]   = grant & (win_idx == IDW'(gi));
         assign UnitMAERR[gi] = pop & MAERR & (head == IDW'(gi));
         assign UnitDRDY[gi]  = pop & DRDY & ~MAERR & (head == IDW'(gi));
      end
   endgenerate

   // Outstanding count: a grant and a pop in the same cycle cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (grant & ~pop)      cnt_d = cnt_q + CW'(1);
      else if (pop & ~grant) cnt_d = cnt_q - CW'(1);
   end

   // Bus output register, FIFO pointers, outstanding count and sticky orphan flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mem_act_q <= 1'b0;
         mem_sel_q <= '0;
         mem_off_q <= '0;
         size_q    <= 1'b0;
         tag_q     <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         orphan_q  <= 1'b0;
      end else begin
         if (grant) begin
            mem_act_q <= 1'b1;
            mem_sel_q <= win_sel;
            mem_off_q <= win_off;
            size_q    <= win_size;
            tag_q     <= win_tag;
         end else if (MemNEXT) begin
            mem_act_q <= 1'b0;
         end
         cnt_q <= cnt_d;
         if (grant) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         if (ret && cnt_q == '0) orphan_q <= 1'b1;
      end
   end

`ifndef NEURO_ARB_FIXPRIO_EN
   // Remember the last winner so the next search starts just after it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)      last_q <= IDW'(NUM_UNITS - 1);
      else if (grant) last_q <= win_idx;
   end
`endif

   // ID FIFO storage; contents are meaningful only between the pointers.
   always_ff @(posedge CLK) begin
      if (grant) fifo_q[wr_ptr_q] <= win_idx;
   end

   assign MemACT    = mem_act_q;
   assign MemSEL    = mem_sel_q;
   assign MemOffset = mem_off_q;
   assign SIZE      = size_q;
   assign TAGo      = tag_q;
   assign ORPHAN    = orphan_q;
   assign UnitTAG   = TAGi;
   assign UnitDT    = DTi;

endmodule

// File: tb/tb_neuro_mem_arbiter.sv
// tb_neuro_mem_arbiter
//   Scoreboard bench. The stimulus task keeps a queue-based reference of the
//   arbiter. It pushes each expected grant, bus handshake and return routing
//   into queues. A separate monitor pops those queues at the falling edge and
//   compares them with the DUT outputs.
`timescale 1ns/1ps
module tb_neuro_mem_arbiter;
   localparam int N   = 4;
   localparam int D   = 4;
   localparam int IDW = 2;

   logic             CLK = 1'b0;
   logic             RESET = 1'b0;
   logic [N-1:0]     ReqACT = '0;
   logic [3*N-1:0]   ReqSEL = '0;
   logic [35*N-1:0]  ReqOffset = '0;
   logic [N-1:0]     ReqSIZE = '0;
   logic [N-1:0]     ReqTAG = '0;
   logic [N-1:0]     ReqNEXT;
   logic             MemACT;
   logic             MemNEXT = 1'b0;
   logic [2:0]       MemSEL;
   logic [34:0]      MemOffset;
   logic             SIZE, TAGo;
   logic             DRDY = 1'b0;
   logic             TAGi = 1'b0;
   logic [63:0]      DTi = '0;
   logic             MAERR = 1'b0;
   logic [N-1:0]     UnitDRDY, UnitMAERR;
   logic             UnitTAG;
   logic [63:0]      UnitDT;
   logic             ORPHAN;

   always #5 CLK = ~CLK;

   neuro_mem_arbiter #(.NUM_UNITS(N), .DEPTH(D), .IDW(IDW)) dut (
      .CLK(CLK), .RESET(RESET),
      .ReqACT(ReqACT), .ReqSEL(ReqSEL), .ReqOffset(ReqOffset),
      .ReqSIZE(ReqSIZE), .ReqTAG(ReqTAG), .ReqNEXT(ReqNEXT),
      .MemACT(MemACT), .MemNEXT(MemNEXT), .MemSEL(MemSEL),
      .MemOffset(MemOffset), .SIZE(SIZE), .TAGo(TAGo),
      .DRDY(DRDY), .TAGi(TAGi), .DTi(DTi), .MAERR(MAERR),
      .UnitDRDY(UnitDRDY), .UnitMAERR(UnitMAERR), .UnitTAG(UnitTAG),
      .UnitDT(UnitDT), .ORPHAN(ORPHAN)
   );

   typedef struct { int cyc; int core; } gnt_t;
   typedef struct { int cyc; logic [2:0] sel; logic [34:0] off; logic size; logic tag; } mem_t;
   typedef struct { int cyc; logic [N-1:0] udrdy; logic [N-1:0] umaerr; logic [63:0] dt; logic tag; } ret_t;

   gnt_t exp_gnt_q[$];
   mem_t exp_mem_q[$];
   ret_t exp_ret_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   // reference state: owners of outstanding reads in issue order, bus register, last winner
   int   m_ids[$];
   int   m_last = N - 1;
   bit   m_pend = 1'b0;
   mem_t m_reg;
   bit   m_orphan = 1'b0;

   // per-core pending request, held until granted or dropped
   bit          c_act [N];
   logic [2:0]  c_sel [N];
   logic [34:0] c_off [N];
   logic        c_size[N];
   logic        c_tag [N];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input string got, input string want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s got %s expected %s (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic clear_model();
      m_ids.delete();
      exp_gnt_q.delete();
      exp_mem_q.delete();
      exp_ret_q.delete();
      m_last   = N - 1;
      m_pend   = 1'b0;
      m_orphan = 1'b0;
      for (int i = 0; i < N; i++) c_act[i] = 1'b0;
   endtask

   task automatic do_reset();
      mon_en  = 1'b0;
      RESET   = 1'b1;
      ReqACT  = '1;
      MemNEXT = 1'b0;
      DRDY    = 1'b0;
      MAERR   = 1'b0;
      #2;
      chk(ReqNEXT == '0 && MemACT == 1'b0 && MemSEL == '0 && MemOffset == '0 &&
          SIZE == 1'b0 && TAGo == 1'b0 && ORPHAN == 1'b0 && UnitDRDY == '0 && UnitMAERR == '0,
          "reset_outputs",
          $sformatf("req=%b act=%b sel=%h off=%h sz=%b tag=%b orph=%b ud=%b um=%b",
                    ReqNEXT, MemACT, MemSEL, MemOffset, SIZE, TAGo, ORPHAN, UnitDRDY, UnitMAERR),
          "all zero");
      @(posedge CLK); #1;
      chk(ReqNEXT == '0 && MemACT == 1'b0, "reset_gate",
          $sformatf("req=%b act=%b", ReqNEXT, MemACT), "req=0000 act=0");
      ReqACT = '0;
      RESET  = 1'b0;
      clear_model();
      mon_en = 1'b1;
   endtask

   // One clock of stimulus; the reference decides the outcome from the request set.
   task automatic drive(input logic [N-1:0] want, input bit mnext, input bit drdy, input bit maerr);
      int   n_out;
      int   w;
      int   o;
      gnt_t g;
      mem_t e;
      ret_t r;
      @(posedge CLK); #1;
      chk(MemACT == m_pend, "memact_state", $sformatf("%b", MemACT), $sformatf("%b", m_pend));
      chk(ORPHAN == m_orphan, "orphan_state", $sformatf("%b", ORPHAN), $sformatf("%b", m_orphan));
      for (int i = 0; i < N; i++) begin
         if (!want[i]) begin
            c_act[i] = 1'b0;
         end else if (!c_act[i]) begin
            c_act[i]  = 1'b1;
            c_sel[i]  = 3'($urandom);
            c_off[i]  = {3'($urandom), 32'($urandom)};
            c_size[i] = 1'($urandom);
            c_tag[i]  = 1'($urandom);
         end
         ReqACT[i]             = c_act[i];
         ReqSEL[3*i +: 3]      = c_sel[i];
         ReqOffset[35*i +: 35] = c_off[i];
         ReqSIZE[i]            = c_size[i];
         ReqTAG[i]             = c_tag[i];
      end
      MemNEXT = mnext;
      DRDY    = drdy;
      MAERR   = maerr;
      DTi     = {$urandom, $urandom};
      TAGi    = 1'($urandom);

      if (m_pend && mnext) begin
         e     = m_reg;
         e.cyc = cyc;
         exp_mem_q.push_back(e);
      end

      n_out = m_ids.size();
      w = -1;
`ifdef NEURO_ARB_FIXPRIO_EN
      for (int k = 0; k < N; k++) if (w < 0 && c_act[k]) w = k;
`else
      for (int k = 1; k <= N; k++) if (w < 0 && c_act[(m_last + k) % N]) w = (m_last + k) % N;
`endif

      if (drdy || maerr) begin
         r.cyc    = cyc;
         r.dt     = DTi;
         r.tag    = TAGi;
         r.udrdy  = '0;
         r.umaerr = '0;
         if (n_out > 0) begin
            o = m_ids.pop_front();
            if (maerr) r.umaerr[o] = 1'b1;
            else       r.udrdy[o]  = 1'b1;
         end else begin
            m_orphan = 1'b1;
         end
         exp_ret_q.push_back(r);
      end

      if (w >= 0 && (!m_pend || mnext) && n_out < D) begin
         g.cyc  = cyc;
         g.core = w;
         exp_gnt_q.push_back(g);
         m_ids.push_back(w);
         m_last     = w;
         m_pend     = 1'b1;
         m_reg.sel  = c_sel[w];
         m_reg.off  = c_off[w];
         m_reg.size = c_size[w];
         m_reg.tag  = c_tag[w];
         c_act[w]   = 1'b0;
      end else if (mnext) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * D; i++) drive('0, 1'b1, m_ids.size() > 0, 1'b0);
   endtask

   // monitor state
   gnt_t         mon_g;
   mem_t         mon_m;
   ret_t         mon_r;
   logic [N-1:0] mon_ev;
   bit           mon_ok;
   bit           mon_hs;

   // Monitor: pops the scoreboard whenever the DUT shows an event or one is due.
   initial begin
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            if (ReqNEXT != '0 || (exp_gnt_q.size() > 0 && exp_gnt_q[0].cyc <= cyc)) begin
               mon_ok = exp_gnt_q.size() > 0;
               mon_ev = '0;
               mon_g.cyc = -1;
               if (mon_ok) begin
                  mon_g = exp_gnt_q.pop_front();
                  mon_ev[mon_g.core] = 1'b1;
               end
               chk(mon_ok && ReqNEXT == mon_ev && mon_g.cyc == cyc, "grant",
                   $sformatf("%b@%0d", ReqNEXT, cyc), $sformatf("%b@%0d", mon_ev, mon_g.cyc));
            end
            mon_hs = MemACT & MemNEXT;
            if (mon_hs || (exp_mem_q.size() > 0 && exp_mem_q[0].cyc <= cyc)) begin
               mon_ok = exp_mem_q.size() > 0;
               mon_m.cyc = -1;
               if (mon_ok) mon_m = exp_mem_q.pop_front();
               chk(mon_ok && mon_hs && mon_m.cyc == cyc && MemSEL == mon_m.sel &&
                   MemOffset == mon_m.off && SIZE == mon_m.size && TAGo == mon_m.tag, "mem_issue",
                   $sformatf("hs=%b sel=%h off=%h sz=%b tag=%b @%0d", mon_hs, MemSEL, MemOffset, SIZE, TAGo, cyc),
                   $sformatf("hs=1 sel=%h off=%h sz=%b tag=%b @%0d", mon_m.sel, mon_m.off, mon_m.size, mon_m.tag, mon_m.cyc));
            end
            if (DRDY || MAERR || UnitDRDY != '0 || UnitMAERR != '0) begin
               mon_ok = exp_ret_q.size() > 0;
               mon_r.cyc = -1;
               mon_r.udrdy = '0;
               mon_r.umaerr = '0;
               if (mon_ok) mon_r = exp_ret_q.pop_front();
               chk(mon_ok && mon_r.cyc == cyc && UnitDRDY == mon_r.udrdy && UnitMAERR == mon_r.umaerr &&
                   UnitDT == mon_r.dt && UnitTAG == mon_r.tag, "return",
                   $sformatf("ud=%b um=%b dt=%h tag=%b @%0d", UnitDRDY, UnitMAERR, UnitDT, UnitTAG, cyc),
                   $sformatf("ud=%b um=%b dt=%h tag=%b @%0d", mon_r.udrdy, mon_r.umaerr, mon_r.dt, mon_r.tag, mon_r.cyc));
            end
         end
      end
   end

   // Stimulus: directed scenarios, a randomized run, a mid-burst reset, then drain.
   initial begin
      #1;
      do_reset();

      // return with nothing outstanding sets the sticky orphan flag
      drive('0, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b1, 1'b0, 1'b1);
      drive('0, 1'b1, 1'b0, 1'b0);
      do_reset();

      // single core request, later its data returns
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b1, 1'b1, 1'b0);

      // all cores requesting: rotation order, returns lag issue
      for (int i = 0; i < 12; i++) drive(4'b1111, 1'b1, m_ids.size() >= 2, 1'b0);
      drain();

      // memory stalls three cycles with a request on the bus
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(4'b1111, 1'b0, 1'b0, 1'b0);
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      drain();

      // ID FIFO full: stall until one read returns
      for (int i = 0; i < 8; i++) drive(4'b0011, 1'b1, 1'b0, 1'b0);
      drive(4'b0011, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(4'b0011, 1'b1, 1'b0, 1'b0);
      drain();

      // cores 2 then 0 outstanding; MAERR and DRDY together, then DRDY
      drive(4'b0100, 1'b1, 1'b0, 1'b0);
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b1, 1'b1, 1'b1);
      drive('0, 1'b1, 1'b1, 1'b0);
      drain();

      // randomized traffic with drops, stalls and errors
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] w;
         for (int k = 0; k < N; k++)
            w[k] = c_act[k] ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
         drive(w, $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(9) == 0);
      end

      // reset in the middle of a burst
      for (int i = 0; i < 6; i++) drive(4'b1111, 1'b1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 10; i++) drive(4'b1111, 1'b1, m_ids.size() >= 3, 1'b0);
      drain();
      drive('0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK); #1;
      chk(exp_gnt_q.size() == 0 && exp_mem_q.size() == 0 && exp_ret_q.size() == 0, "scoreboard_empty",
          $sformatf("%0d/%0d/%0d", exp_gnt_q.size(), exp_mem_q.size(), exp_ret_q.size()), "0/0/0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
